// File: rtl/tseq_pkg.sv
// Shared types and helpers for the test sequencer.
package tseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tseq_state_e;

    // Timer counts 0..timeout-1; keep at least one bit for timeout == 1.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/tseq_timer.sv
// Per-unit run timer: counts while enabled, flags the last allowed cycle.
module tseq_timer
    import tseq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned   TW   = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + TW'(1);
        end
    end

    assign expired_c = enable && (count == LAST);

endmodule

// File: rtl/test_sequencer.sv
// Runs N_UNITS units in order with a per-unit timeout and sticky verdict masks.
// Define TSEQ_STOP_ON_FAIL_EN to end the chain at the first failing unit.
module test_sequencer
    import tseq_pkg::*;
#(
    parameter int unsigned N_UNITS = 6,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic [N_UNITS-1:0]         unit_start,
    input  logic [N_UNITS-1:0]         unit_finish,
    input  logic [N_UNITS-1:0]         unit_pass,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_UNITS)-1:0] cur_idx,
    output logic [N_UNITS-1:0]         fail_mask,
    output logic [N_UNITS-1:0]         timeout_mask
);

    localparam int unsigned      IDX_W    = $clog2(N_UNITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);

    tseq_state_e        state_q, state_d;
    logic [IDX_W-1:0]   cur_idx_d;
    logic [N_UNITS-1:0] fail_d, timeout_d, start_d;
    logic               busy_d, done_d;
    logic               fin_c, pass_c, expired_c, leave_c, failed_c;

    assign fin_c  = unit_finish[cur_idx];
    assign pass_c = unit_pass[cur_idx];

    // Timer is held at zero outside RUN, so every RUN visit starts counting from 0.
    tseq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q != RUN),
        .enable    (state_q == RUN),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cur_idx      <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            unit_start   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx      <= cur_idx_d;
            fail_mask    <= fail_d;
            timeout_mask <= timeout_d;
            unit_start   <= start_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx;
        fail_d    = fail_mask;
        timeout_d = timeout_mask;
        leave_c   = 1'b0;
        failed_c  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d   = RUN;
                    cur_idx_d = '0;
                    fail_d    = '0;
                    timeout_d = '0;
                end
            end
            RUN: begin
                // Finish wins over a simultaneous timeout.
                if (fin_c) begin
                    leave_c  = 1'b1;
                    failed_c = !pass_c;
                end else if (expired_c) begin
                    leave_c            = 1'b1;
                    failed_c           = 1'b1;
                    timeout_d[cur_idx] = 1'b1;
                end
                if (failed_c) begin
                    fail_d[cur_idx] = 1'b1;
                end
                if (leave_c) begin
`ifdef TSEQ_STOP_ON_FAIL_EN
                    state_d = (failed_c || cur_idx == LAST_IDX) ? DONE : GAP;
`else
                    state_d = (cur_idx == LAST_IDX) ? DONE : GAP;
`endif
                end
            end
            GAP: begin
                state_d   = RUN;
                cur_idx_d = cur_idx + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        start_d = (state_d == RUN) ? (N_UNITS'(1) << cur_idx_d) : '0;
        busy_d  = (state_d == RUN) || (state_d == GAP);
        done_d  = (state_d == DONE);
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer with N_UNITS=3, TIMEOUT=16.
module tb_test_sequencer;

    localparam int N  = 3;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [N-1:0] unit_start;
    logic [N-1:0] unit_finish;
    logic [N-1:0] unit_pass;
    logic         busy;
    logic         done;
    logic [1:0]   cur_idx;
    logic [N-1:0] fail_mask;
    logic [N-1:0] timeout_mask;

    int n_cmp = 0;
    int n_err = 0;

    // Unit responder model: lat[i] cycles of start before finish (<=0: never).
    int lat [N];
    int cnt [N];
    bit noise;
    int exp_q [$];

    test_sequencer #(
        .N_UNITS (N),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .unit_start   (unit_start),
        .unit_finish  (unit_finish),
        .unit_pass    (unit_pass),
        .busy         (busy),
        .done         (done),
        .cur_idx      (cur_idx),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (unit_start[i]) cnt[i] = cnt[i] + 1;
            else               cnt[i] = 0;
            unit_finish[i] = unit_start[i] ? (lat[i] > 0 && cnt[i] >= lat[i]) : noise;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"}, 32'(unit_start), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_idx"}, 32'(cur_idx), 32'h0);
        check({tag, "_fail"}, 32'(fail_mask), 32'h0);
        check({tag, "_tmo"}, 32'(timeout_mask), 32'h0);
    endtask

    // Build expectations from lat/unit_pass, pulse go, then score the chain.
    task automatic run_chain(input int go_a, input int go_b);
        logic [N-1:0] e_fail, e_to, prev;
        int           e_last, e_len [N], runl [N], zero_run, e;
        bit           first, seen_done;

        e_fail = '0;
        e_to   = '0;
        e_last = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            e_len[i] = 0;
            runl[i]  = 0;
        end
        for (int i = 0; i < N; i++) begin
            bit t, f;
            t         = (lat[i] <= 0) || (lat[i] > TO);
            f         = t || !unit_pass[i];
            e_to[i]   = t;
            e_fail[i] = f;
            e_len[i]  = t ? TO : lat[i];
            e_last    = i;
            exp_q.push_back(i);
`ifdef TSEQ_STOP_ON_FAIL_EN
            if (f) break;
`endif
        end

        go = 1'b1;
        tick();
        go = 1'b0;

        prev      = '0;
        first     = 1'b1;
        zero_run  = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            check("start_onehot", 32'($countones(unit_start) <= 1), 32'h1);
            for (int i = 0; i < N; i++) begin
                if (unit_start[i]) runl[i] = runl[i] + 1;
                if (unit_start[i] && !prev[i]) begin
                    if (exp_q.size() == 0) begin
                        check("extra_start", 32'(i), 32'hff);
                    end else begin
                        e = exp_q.pop_front();
                        check("start_order", 32'(i), 32'(e));
                        check("cur_idx_run", 32'(cur_idx), 32'(e));
                        if (!first) check("gap_len", 32'(zero_run), 32'h1);
                        first    = 1'b0;
                        zero_run = 0;
                    end
                end
            end
            if (busy && unit_start == '0) zero_run++;
            prev = unit_start;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (cyc == go_a || cyc == go_b) go = 1'b1;
            tick();
            go = 1'b0;
        end

        if (!seen_done) check("done_reached", 32'h0, 32'h1);
        check("units_left", 32'(exp_q.size()), 32'h0);
        check("done", 32'(done), 32'h1);
        check("busy_done", 32'(busy), 32'h0);
        check("start_done", 32'(unit_start), 32'h0);
        check("cur_idx_done", 32'(cur_idx), 32'(e_last));
        check("fail_mask", 32'(fail_mask), 32'(e_fail));
        check("timeout_mask", 32'(timeout_mask), 32'(e_to));
        for (int i = 0; i < N; i++) check("run_len", 32'(runl[i]), 32'(e_len[i]));
    endtask

    initial begin
        rst         = 1'b0;
        go          = 1'b0;
        unit_finish = '0;
        unit_pass   = '1;
        noise       = 1'b0;
        for (int i = 0; i < N; i++) begin
            lat[i] = 5;
            cnt[i] = 0;
        end

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        tick();
        check_idle_outputs("idle");

        // All pass after 5 cycles; go pulses in RUN and in GAP must be ignored
        run_chain(3, 5);
        repeat (3) tick();
        check("done_sticky", 32'(done), 32'h1);
        check("idx_hold", 32'(cur_idx), 32'(N - 1));

        // Unit 1 fails; idle units show spurious finish
        unit_pass = 3'b101;
        noise     = 1'b1;
        run_chain(-1, -1);
        noise     = 1'b0;

        // Unit 0 never finishes
        unit_pass = '1;
        lat[0]    = 0;
        run_chain(-1, -1);

        // Finish exactly on the timeout edge
        lat[0]    = TO;
        lat[1]    = TO;
        lat[2]    = 3;
        unit_pass = 3'b101;
        run_chain(-1, -1);

        // Reset while unit 1 runs
        for (int i = 0; i < N; i++) lat[i] = 5;
        unit_pass = 3'b110;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 40 && !unit_start[1]; c++) tick();
        check("reach_unit1", 32'(unit_start[1]), 32'h1);
        tick();
        tick();
        check("pre_rst_fail", 32'(fail_mask), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        unit_finish = '0;
        unit_pass   = '1;
        run_chain(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
